mem_arbiter: RTL and testbench

//  Shares the single memory4c main memory between the icache fill path and the dcache fill/write path.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory4c between icache block fills and dcache fills/single-word writes.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of favouring the dcache.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req,
   input  logic [ADDR_W-1:0]         i_addr,
   output logic                      i_grant,
   output logic                      i_word_valid,
   output logic [$clog2(WORDS)-1:0]  i_word_idx,
   output logic                      i_done,
   input  logic                      d_req,
   input  logic                      d_wr,
   input  logic [ADDR_W-1:0]         d_addr,
   input  logic [DATA_W-1:0]         d_wdata,
   output logic                      d_grant,
   output logic                      d_word_valid,
   output logic [$clog2(WORDS)-1:0]  d_word_idx,
   output logic                      d_done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_enable,
   output logic                      mem_wr,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_data_valid
);

   localparam int IDX_W = $clog2(WORDS);
   localparam int OFF_W = IDX_W + 1;
   localparam int CNT_W = IDX_W + 1;
   localparam int BLK_W = ADDR_W - OFF_W;
   localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL_I = 2'd1,
      FILL_D = 2'd2,
      WRITE  = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [BLK_W-1:0]    blk_r, blk_s;
   logic [ADDR_W-1:0]   waddr_r, waddr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [CNT_W-1:0]    issue_cnt_r, issue_cnt_s;
   logic [IDX_W-1:0]    recv_cnt_r, recv_cnt_s;
   logic                pick_d_s;
   logic                unused_s;

   // Offset bits below the block boundary and the write byte bit never reach memory.
   assign unused_s = ^{i_addr[OFF_W-1:0], d_addr[0]};

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner_r;  // 1 = dcache was granted last

   // Tie goes to whichever requester was not granted last.
   always_comb begin
      pick_d_s = 1'b0;
      if (i_req && d_req) begin
         pick_d_s = ~last_owner_r;
      end else begin
         pick_d_s = d_req;
      end
   end

   // Remember the most recent grant owner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_owner_r <= 1'b0;
      end else if ((state_r == IDLE) && (i_req || d_req)) begin
         last_owner_r <= pick_d_s;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end
`else
   // Fixed priority: dcache wins whenever it requests.
   always_comb begin
      pick_d_s = 1'b0;
      if (d_req) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
   end
`endif

   // Next-state, counter and output decode.
   always_comb begin
      state_s      = state_r;
      blk_s        = blk_r;
      waddr_s      = waddr_r;
      wdata_s      = wdata_r;
      issue_cnt_s  = issue_cnt_r;
      recv_cnt_s   = recv_cnt_r;
      i_grant      = 1'b0;
      i_word_valid = 1'b0;
      i_word_idx   = {IDX_W{1'b0}};
      i_done       = 1'b0;
      d_grant      = 1'b0;
      d_word_valid = 1'b0;
      d_word_idx   = {IDX_W{1'b0}};
      d_done       = 1'b0;
      rdata        = {DATA_W{1'b0}};
      mem_addr     = {ADDR_W{1'b0}};
      mem_wdata    = {DATA_W{1'b0}};
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      busy         = (state_r != IDLE);

      case (state_r)
         IDLE: begin
            issue_cnt_s = {CNT_W{1'b0}};
            recv_cnt_s  = {IDX_W{1'b0}};
            if (i_req || d_req) begin
               if (pick_d_s) begin
                  blk_s   = d_addr[ADDR_W-1:OFF_W];
                  waddr_s = {d_addr[ADDR_W-1:1], 1'b0};
                  wdata_s = d_wdata;
                  if (d_wr) begin
                     state_s = WRITE;
                  end else begin
                     state_s = FILL_D;
                  end
               end else begin
                  blk_s   = i_addr[ADDR_W-1:OFF_W];
                  state_s = FILL_I;
               end
            end else begin
               state_s = IDLE;
            end
         end

         FILL_I, FILL_D: begin
            i_grant = (state_r == FILL_I);
            d_grant = (state_r == FILL_D);
            if (issue_cnt_r < ISSUE_MAX) begin
               mem_enable  = 1'b1;
               mem_addr    = {blk_r, issue_cnt_r[IDX_W-1:0], 1'b0};
               issue_cnt_s = issue_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               issue_cnt_s = issue_cnt_r;
            end
            // Returned words go only to the current owner.
            if (mem_data_valid) begin
               rdata        = mem_rdata;
               i_word_valid = (state_r == FILL_I);
               d_word_valid = (state_r == FILL_D);
               i_word_idx   = (state_r == FILL_I) ? recv_cnt_r : {IDX_W{1'b0}};
               d_word_idx   = (state_r == FILL_D) ? recv_cnt_r : {IDX_W{1'b0}};
               recv_cnt_s   = recv_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
               if (recv_cnt_r == LAST_IDX) begin
                  i_done  = (state_r == FILL_I);
                  d_done  = (state_r == FILL_D);
                  state_s = IDLE;
               end else begin
                  state_s = state_r;
               end
            end else begin
               recv_cnt_s = recv_cnt_r;
            end
         end

         WRITE: begin
            d_grant    = 1'b1;
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = waddr_r;
            mem_wdata  = wdata_r;
            d_done     = 1'b1;
            state_s    = IDLE;
         end

         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         blk_r       <= {BLK_W{1'b0}};
         waddr_r     <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         issue_cnt_r <= {CNT_W{1'b0}};
         recv_cnt_r  <= {IDX_W{1'b0}};
      end else begin
         state_r     <= state_s;
         blk_r       <= blk_s;
         waddr_r     <= waddr_s;
         wdata_r     <= wdata_s;
         issue_cnt_r <= issue_cnt_s;
         recv_cnt_r  <= recv_cnt_s;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a latency-4 memory model.
// Expected behaviour comes from a transaction-level schedule of the arbitration and burst rules.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_grant, i_word_valid, i_done;
   logic [2:0]  i_word_idx;
   logic        d_req, d_wr;
   logic [15:0] d_addr, d_wdata;
   logic        d_grant, d_word_valid, d_done;
   logic [2:0]  d_word_idx;
   logic [15:0] rdata;
   logic        busy;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_enable, mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_data_valid;

   int passed = 0;
   int total  = 0;
   bit last_d = 1'b0;

   bit [15:0] mem_arr     [0:65535];
   bit        mem_written [0:65535];
   bit [3:0]  pv = 4'd0;
   bit [15:0] pd [0:3];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_word_valid(i_word_valid),
      .i_word_idx(i_word_idx), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
      .d_word_valid(d_word_valid), .d_word_idx(d_word_idx), .d_done(d_done),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
   );

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      if (mem_written[a]) return mem_arr[a];
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // memory4c stand-in: writes land at once, reads return four cycles after issue
   always @(posedge clk) begin
      if (mem_enable && mem_wr) begin
         mem_arr[mem_addr]     <= mem_wdata;
         mem_written[mem_addr] <= 1'b1;
      end
      pv    <= {pv[2:0], mem_enable && !mem_wr};
      pd[0] <= mem_val(mem_addr);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
   end
   assign mem_data_valid = pv[3];
   assign mem_rdata      = pd[3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arbitration rule: lone requester wins; ties go to dcache (or alternate in round-robin builds).
   function automatic bit model_pick(input bit ir, input bit dr);
      bit p;
      if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
         p = !last_d;
`else
         p = 1'b1;
`endif
      end else begin
         p = dr;
      end
      last_d = p;
      return p;
   endfunction

   // Walks the 12 cycles of a block fill that started in the current IDLE cycle.
   task automatic do_fill(input bit own_d, input logic [15:0] addr, input int drop_at, input string tag);
      logic [15:0] base;
      logic [8:0]  obs, exp;
      bit          en, v;
      int          j;
      base = {addr[15:4], 4'h0};
      for (int k = 1; k <= 12; k++) begin
         tick();
         en  = (k <= 8);
         v   = (k >= 5);
         obs = {i_grant, d_grant, mem_enable, mem_wr, i_word_valid, d_word_valid, i_done, d_done, busy};
         exp = {!own_d, own_d, en, 1'b0, v && !own_d, v && own_d, (k == 12) && !own_d, (k == 12) && own_d, 1'b1};
         total++;
         if (obs !== exp) $display("FAIL %s ctl k=%0d got %b want %b", tag, k, obs, exp);
         else passed++;
         if (en) begin
            total++;
            if (mem_addr !== base + 16'(2 * (k - 1)))
               $display("FAIL %s mem_addr k=%0d got %h want %h", tag, k, mem_addr, base + 16'(2 * (k - 1)));
            else passed++;
         end
         if (v) begin
            j = k - 5;
            total++;
            if ((own_d ? d_word_idx : i_word_idx) !== 3'(j))
               $display("FAIL %s word_idx k=%0d got %0d want %0d", tag, k, own_d ? d_word_idx : i_word_idx, j);
            else passed++;
            total++;
            if (rdata !== mem_val(base + 16'(2 * j)))
               $display("FAIL %s rdata k=%0d got %h want %h", tag, k, rdata, mem_val(base + 16'(2 * j)));
            else passed++;
         end
         if (k == drop_at) d_req = 1'b0;
      end
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [15:0] wd, input string tag);
      logic [8:0] obs;
      tick();
      obs = {i_grant, d_grant, mem_enable, mem_wr, i_word_valid, d_word_valid, i_done, d_done, busy};
      total++;
      if (obs !== 9'b011100011) $display("FAIL %s ctl got %b want %b", tag, obs, 9'b011100011);
      else passed++;
      total++;
      if ({mem_addr, mem_wdata} !== {addr[15:1], 1'b0, wd})
         $display("FAIL %s addr/data got %h/%h want %h/%h", tag, mem_addr, mem_wdata, {addr[15:1], 1'b0}, wd);
      else passed++;
   endtask

   task automatic idle_check(input string tag);
      logic [7:0] obs;
      tick();
      obs = {i_grant, d_grant, mem_enable, i_word_valid, d_word_valid, i_done, d_done, busy};
      total++;
      if (obs !== 8'h00) $display("FAIL %s idle got %b want 00000000", tag, obs);
      else passed++;
   endtask

   task automatic run_op(input bit ir, input logic [15:0] ia, input bit dr, input bit dw,
                         input logic [15:0] da, input logic [15:0] dwd, input string tag);
      bit own;
      i_req = ir; i_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd;
      own = model_pick(ir, dr);
      if (own && dw) do_write(da, dwd, tag);
      else do_fill(own, own ? da : ia, 0, tag);
      i_req = 1'b0; d_req = 1'b0;
      idle_check(tag);
   endtask

   task automatic test_reset();
      logic [63:0] obs;
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
      repeat (3) tick();
      obs = {i_grant, i_word_valid, i_word_idx, i_done, d_grant, d_word_valid, d_word_idx, d_done,
             busy, mem_enable, mem_wr, rdata, mem_addr, mem_wdata, 2'b00};
      total++;
      if (obs !== 64'd0) $display("FAIL reset outputs got %h want 0", obs);
      else passed++;
      rst = 1'b1;
      last_d = 1'b0;
      idle_check("reset_idle");
   endtask

   task automatic test_lone_fill();
      run_op(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, "lone_i");
   endtask

   task automatic test_tie();
      bit own;
      i_req = 1'b1; i_addr = 16'($urandom); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
      own = model_pick(1'b1, 1'b1);
      do_fill(own, own ? d_addr : i_addr, 0, "tie_first");
      if (own) d_req = 1'b0; else i_req = 1'b0;
      idle_check("tie_gap");
      own = model_pick(i_req, d_req);
      do_fill(own, own ? d_addr : i_addr, 0, "tie_second");
      i_req = 1'b0; d_req = 1'b0;
      idle_check("tie_end");
   endtask

   task automatic test_write();
      run_op(1'b0, 16'h0, 1'b1, 1'b1, 16'h00A1, 16'hBEEF, "write");
      run_op(1'b1, 16'h00A5, 1'b0, 1'b0, 16'h0, 16'h0, "fill_after_write");
   endtask

   task automatic test_reset_mid_fill();
      logic [7:0] obs;
      logic [15:0] ia;
      bit own;
      ia = 16'($urandom);
      i_req = 1'b1; i_addr = ia;
      own = model_pick(1'b1, 1'b0);
      for (int k = 1; k <= 7; k++) tick();
      total++;
      if ({own, i_word_valid, i_word_idx} !== {1'b0, 1'b1, 3'd2})
         $display("FAIL rst_mid third_valid got %b want 0_1_010", {own, i_word_valid, i_word_idx});
      else passed++;
      rst = 1'b0; i_req = 1'b0;
      tick();
      obs = {i_grant, i_word_valid, i_done, mem_enable, busy, |rdata, |mem_addr, |i_word_idx};
      total++;
      if (obs !== 8'h00) $display("FAIL rst_mid outputs got %b want 00000000", obs);
      else passed++;
      rst = 1'b1;
      last_d = 1'b0;
      for (int k = 0; k < 6; k++) idle_check("rst_stray");
      run_op(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0, "rst_refill");
   endtask

   task automatic test_back_to_back();
      bit own;
      i_req = 1'b1; i_addr = 16'($urandom); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
      for (int op = 0; op < 4; op++) begin
         own = model_pick(1'b1, 1'b1);
         do_fill(own, own ? d_addr : i_addr, 0, $sformatf("b2b_op%0d", op));
         if (op == 3) begin
            i_req = 1'b0; d_req = 1'b0;
         end
         idle_check("b2b_gap");
      end
   endtask

   task automatic test_drop();
      bit own;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom); i_req = 1'b0;
      own = model_pick(1'b0, 1'b1);
      do_fill(own, d_addr, 2, "drop_d");
      idle_check("drop_end");
      idle_check("drop_quiet");
   endtask

   task automatic test_random();
      bit ir, dr;
      for (int n = 0; n < 12; n++) begin
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         if (!ir && !dr) dr = 1'b1;
         run_op(ir, 16'($urandom), dr, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_lone_fill();
      test_tie();
      test_write();
      test_reset_mid_fill();
      test_back_to_back();
      test_drop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
